escalonador_requisicoes: RTL and testbench
==========================================

Name: escalonador_requisicoes

Overview:
- Sits directly upstream of gerenciador_ativos, between the active-node evaluator and that block.
- Buffers deactivate requests and update requests from the evaluator in two independent circular queues.
- Issues requests one at a time as single-cycle pulses, and only when gerenciador_ativos is idle.
- Deactivations have strict priority because they free NA slots. Updates are withheld while no NA slot is free, which prevents a deadlock in which a pending update waits for a slot that only a queued deactivation can release.

Parameters:
- ADDR_WIDTH, 5, node address width.
- DISTANCIA_WIDTH, 5, accumulated distance width.
- CUSTO_WIDTH, 4, neighbour cost width.
- FILA_DEPTH, 8, entries per queue; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous and active-low.
- req_desativar_in  in  1  enqueue a deactivate request this cycle.
- des_endereco_in  in  ADDR_WIDTH  address of the node to deactivate.
- req_atualizar_in  in  1  enqueue an update request this cycle.
- atu_endereco_in  in  ADDR_WIDTH  address of the node to update.
- atu_anterior_in  in  ADDR_WIDTH  predecessor node.
- atu_menor_vizinho_in  in  CUSTO_WIDTH  smallest neighbour cost.
- atu_distancia_in  in  DISTANCIA_WIDTH  distance.
- ga_ocupado_i  in  1  gerenciador_ativos busy.
- ga_buffers_cheios_i  in  1  gerenciador_ativos has no free NA slot.
- er_desativar_out  out  1  deactivate pulse to gerenciador_ativos.
- er_atualizar_out  out  1  update pulse to gerenciador_ativos.
- er_endereco_out  out  ADDR_WIDTH  address of the issued request.
- er_anterior_out  out  ADDR_WIDTH  predecessor of the issued request.
- er_menor_vizinho_out  out  CUSTO_WIDTH  cost field of the issued request.
- er_distancia_out  out  DISTANCIA_WIDTH  distance field of the issued request.
- er_fila_des_cheia_o  out  1  deactivate queue full.
- er_fila_atu_cheia_o  out  1  update queue full.
- er_vazio_o  out  1  both queues empty and FSM in ST_IDLE.
- er_overflow_o  out  1  sticky flag: a request was dropped.

Behaviour:
- Reset: all logic is synchronous to clk, active while rst_n=0. Reset takes priority over every other event, including mid-operation.
  - All outputs go to 0.
  - Both queues are emptied: pointers and counts go to 0.
  - The FSM goes to ST_IDLE.
  - er_overflow_o is cleared.
  - Requests presented during reset are ignored.
- Queues:
  - Each queue has read and write pointers of width clog2(FILA_DEPTH), wrapping modulo FILA_DEPTH.
  - Each queue has an occupancy count of width clog2(FILA_DEPTH)+1.
  - Deactivate entry: {endereco}. Update entry: {endereco, anterior, menor_vizinho, distancia}.
  - Both queues may be written in the same cycle.
  - A write to a full queue is dropped and sets er_overflow_o (sticky until reset). This holds even if a pop happens in that same cycle.
  - A write and a pop in the same cycle on a non-full queue leave the count unchanged.
  - The cheia flags are combinational: count == FILA_DEPTH.
- FSM states: ST_IDLE, ST_EMITIDO, ST_ESPERA.
- ST_IDLE:
  - If ga_ocupado_i=0 and the deactivate queue is not empty: pop the deactivate queue. Register er_desativar_out=1 and er_endereco_out=entry; the other payload outputs keep their values. Go to ST_EMITIDO.
  - Else, if ga_ocupado_i=0, the update queue is not empty and ga_buffers_cheios_i=0: pop the update queue. Register er_atualizar_out=1 and all four payload fields. Go to ST_EMITIDO.
  - Otherwise stay in ST_IDLE.
- ST_EMITIDO (one cycle): the pulse drops to 0 at the next edge, so each pulse is exactly 1 cycle wide. Go to ST_ESPERA. This state covers the cycle gerenciador_ativos needs to raise busy.
- ST_ESPERA: stay while ga_ocupado_i=1; go to ST_IDLE once ga_ocupado_i=0.
- Never more than one request is outstanding. er_desativar_out and er_atualizar_out are never high together.
- Payload outputs hold their last issued value until the next pop.
- Latency: a request sampled at edge t, with both queues empty, the FSM in ST_IDLE and ga_ocupado_i=0, produces a pulse high between edges t+1 and t+2.
- Minimum spacing between consecutive pulses is 3 cycles: ST_EMITIDO, ST_ESPERA with ga_ocupado_i=0, then ST_IDLE pops.
- Starvation rule: updates are only considered when the deactivate queue is empty. This is intentional.
- er_vazio_o is combinational.

Test Plan:
- Single deactivate: reset, then req_desativar_in=1 with des_endereco_in=5 for one cycle, ga_ocupado_i=0 -> er_desativar_out=1 for exactly one cycle, 2 cycles after the request; er_endereco_out=5; er_vazio_o=1 afterwards.
- Priority: same cycle, a deactivate with endereco=3 and an update with endereco=7, anterior=2, menor_vizinho=4, distancia=9 -> the deactivate for 3 issues first. The update for 7/2/4/9 issues only after ga_ocupado_i has returned to 0.
- Busy hold: ga_ocupado_i held at 1 for 10 cycles with 3 updates queued -> no pulses. After release, 3 pulses in FIFO order, each separated by the ga_ocupado_i high/low handshake.
- Slot gating: ga_buffers_cheios_i=1 with 1 update queued -> no pulse. Then a deactivate arrives -> the deactivate issues. Then ga_buffers_cheios_i=0 -> the update issues.
- Overflow and wrap: 9 updates written with ga_ocupado_i=1 (FILA_DEPTH=8) -> er_fila_atu_cheia_o=1 and er_overflow_o=1; the 9th is dropped; draining yields the first 8 in order. Refill 8 more -> the pointers wrap and the order is still correct.
- Reset mid-operation: rst_n=0 for one cycle while in ST_ESPERA with 4 entries queued -> all outputs 0, er_vazio_o=1, er_overflow_o=0; no pulses afterwards without new requests.

Source files
------------

// File: rtl/escalonador_requisicoes.sv
// Request scheduler between the active-node evaluator and gerenciador_ativos.
// Latency: a request enqueued at edge t on an idle, empty block pulses between edges t+1 and t+2.
// Backpressure: issues only while ga_ocupado_i=0; a write to a full queue is dropped and flagged.
//
// Ports:
//   clk, rst_n                    clock and synchronous active-low reset
//   req_desativar_in, des_*_in    deactivate request enqueue
//   req_atualizar_in, atu_*_in    update request enqueue
//   ga_ocupado_i                  gerenciador_ativos busy
//   ga_buffers_cheios_i           gerenciador_ativos has no free NA slot
//   er_desativar_out, er_atualizar_out   single-cycle request pulses
//   er_endereco/anterior/menor_vizinho/distancia_out   payload of the last issued request
//   er_fila_des_cheia_o, er_fila_atu_cheia_o, er_vazio_o, er_overflow_o   status

// Circular queue: combinational head, registered pointers and count.
// Latency: an entry written at edge t is visible at the head after edge t.
// Backpressure: a write while full is dropped and reported on descarte, even if a pop coincides.
module escalonador_fila #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             cheia,
  output logic             vazia,
  output logic             descarte
);
  // DEPTH must be a power of two so the pointers wrap by simple overflow.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign cheia    = (cnt == CW'(DEPTH));
  assign vazia    = (cnt == '0);
  // Fullness is judged before any same-cycle pop, so a full queue never accepts.
  assign push_ok  = push && !cheia;
  assign pop_ok   = pop && !vazia;
  assign descarte = push && cheia;
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module escalonador_requisicoes #(
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CUSTO_WIDTH     = 4,
  parameter int FILA_DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_desativar_in,
  input  logic [ADDR_WIDTH-1:0]      des_endereco_in,
  input  logic                       req_atualizar_in,
  input  logic [ADDR_WIDTH-1:0]      atu_endereco_in,
  input  logic [ADDR_WIDTH-1:0]      atu_anterior_in,
  input  logic [CUSTO_WIDTH-1:0]     atu_menor_vizinho_in,
  input  logic [DISTANCIA_WIDTH-1:0] atu_distancia_in,
  input  logic                       ga_ocupado_i,
  input  logic                       ga_buffers_cheios_i,
  output logic                       er_desativar_out,
  output logic                       er_atualizar_out,
  output logic [ADDR_WIDTH-1:0]      er_endereco_out,
  output logic [ADDR_WIDTH-1:0]      er_anterior_out,
  output logic [CUSTO_WIDTH-1:0]     er_menor_vizinho_out,
  output logic [DISTANCIA_WIDTH-1:0] er_distancia_out,
  output logic                       er_fila_des_cheia_o,
  output logic                       er_fila_atu_cheia_o,
  output logic                       er_vazio_o,
  output logic                       er_overflow_o
);
  localparam int ATU_W = 2 * ADDR_WIDTH + CUSTO_WIDTH + DISTANCIA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMITIDO,
    ST_ESPERA
  } estado_t;

  estado_t estado;

  logic [ADDR_WIDTH-1:0]      des_dat;
  logic                       des_vazia;
  logic                       des_descarte;
  logic                       pop_des;

  logic [ATU_W-1:0]           atu_dat;
  logic                       atu_vazia;
  logic                       atu_descarte;
  logic                       pop_atu;

  logic [ADDR_WIDTH-1:0]      atu_end;
  logic [ADDR_WIDTH-1:0]      atu_ant;
  logic [CUSTO_WIDTH-1:0]     atu_men;
  logic [DISTANCIA_WIDTH-1:0] atu_dist;

  assign {atu_end, atu_ant, atu_men, atu_dist} = atu_dat;

  escalonador_fila #(.WIDTH(ADDR_WIDTH), .DEPTH(FILA_DEPTH)) u_fila_des (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (req_desativar_in),
    .push_dat (des_endereco_in),
    .pop      (pop_des),
    .pop_dat  (des_dat),
    .cheia    (er_fila_des_cheia_o),
    .vazia    (des_vazia),
    .descarte (des_descarte)
  );

  escalonador_fila #(.WIDTH(ATU_W), .DEPTH(FILA_DEPTH)) u_fila_atu (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (req_atualizar_in),
    .push_dat ({atu_endereco_in, atu_anterior_in, atu_menor_vizinho_in, atu_distancia_in}),
    .pop      (pop_atu),
    .pop_dat  (atu_dat),
    .cheia    (er_fila_atu_cheia_o),
    .vazia    (atu_vazia),
    .descarte (atu_descarte)
  );

  // Deactivations always win: they free NA slots. Updates wait for an empty
  // deactivate queue and a free slot, otherwise an update could block the
  // very deactivation that would release its slot.
  always_comb begin
    pop_des = 1'b0;
    pop_atu = 1'b0;
    if (estado == ST_IDLE && !ga_ocupado_i) begin
      if (!des_vazia) begin
        pop_des = 1'b1;
      end else if (!atu_vazia && !ga_buffers_cheios_i) begin
        pop_atu = 1'b1;
      end
    end
  end

  assign er_vazio_o = des_vazia && atu_vazia && (estado == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado               <= ST_IDLE;
      er_desativar_out     <= 1'b0;
      er_atualizar_out     <= 1'b0;
      er_endereco_out      <= '0;
      er_anterior_out      <= '0;
      er_menor_vizinho_out <= '0;
      er_distancia_out     <= '0;
    end else begin
      // Pulses last exactly one cycle; payload holds until the next pop.
      er_desativar_out <= 1'b0;
      er_atualizar_out <= 1'b0;
      case (estado)
        ST_IDLE: begin
          if (pop_des) begin
            er_desativar_out <= 1'b1;
            er_endereco_out  <= des_dat;
            estado           <= ST_EMITIDO;
          end else if (pop_atu) begin
            er_atualizar_out     <= 1'b1;
            er_endereco_out      <= atu_end;
            er_anterior_out      <= atu_ant;
            er_menor_vizinho_out <= atu_men;
            er_distancia_out     <= atu_dist;
            estado               <= ST_EMITIDO;
          end
        end
        // Gives gerenciador_ativos one cycle to raise busy before we look at it.
        ST_EMITIDO: estado <= ST_ESPERA;
        ST_ESPERA: begin
          if (!ga_ocupado_i) estado <= ST_IDLE;
        end
        default: estado <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      er_overflow_o <= 1'b0;
    end else if (des_descarte || atu_descarte) begin
      er_overflow_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_escalonador_requisicoes.sv
module tb_escalonador_requisicoes;
  localparam int AW = 5;
  localparam int DW = 5;
  localparam int CWD = 4;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [AW-1:0]  e;
    logic [AW-1:0]  a;
    logic [CWD-1:0] m;
    logic [DW-1:0]  d;
  } atu_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_desativar_in;
  logic [AW-1:0]  des_endereco_in;
  logic           req_atualizar_in;
  logic [AW-1:0]  atu_endereco_in;
  logic [AW-1:0]  atu_anterior_in;
  logic [CWD-1:0] atu_menor_vizinho_in;
  logic [DW-1:0]  atu_distancia_in;
  logic           ga_ocupado_i;
  logic           ga_buffers_cheios_i;
  logic           er_desativar_out;
  logic           er_atualizar_out;
  logic [AW-1:0]  er_endereco_out;
  logic [AW-1:0]  er_anterior_out;
  logic [CWD-1:0] er_menor_vizinho_out;
  logic [DW-1:0]  er_distancia_out;
  logic           er_fila_des_cheia_o;
  logic           er_fila_atu_cheia_o;
  logic           er_vazio_o;
  logic           er_overflow_o;

  int checks = 0;
  int errors = 0;
  atu_t last_atu;

  escalonador_requisicoes #(
    .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CUSTO_WIDTH(CWD), .FILA_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_desativar_in(req_desativar_in), .des_endereco_in(des_endereco_in),
    .req_atualizar_in(req_atualizar_in), .atu_endereco_in(atu_endereco_in),
    .atu_anterior_in(atu_anterior_in), .atu_menor_vizinho_in(atu_menor_vizinho_in),
    .atu_distancia_in(atu_distancia_in),
    .ga_ocupado_i(ga_ocupado_i), .ga_buffers_cheios_i(ga_buffers_cheios_i),
    .er_desativar_out(er_desativar_out), .er_atualizar_out(er_atualizar_out),
    .er_endereco_out(er_endereco_out), .er_anterior_out(er_anterior_out),
    .er_menor_vizinho_out(er_menor_vizinho_out), .er_distancia_out(er_distancia_out),
    .er_fila_des_cheia_o(er_fila_des_cheia_o), .er_fila_atu_cheia_o(er_fila_atu_cheia_o),
    .er_vazio_o(er_vazio_o), .er_overflow_o(er_overflow_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_desativar_in     = 1'b0;
    des_endereco_in      = '0;
    req_atualizar_in     = 1'b0;
    atu_endereco_in      = '0;
    atu_anterior_in      = '0;
    atu_menor_vizinho_in = '0;
    atu_distancia_in     = '0;
  endtask

  task automatic drive_atu(input atu_t v);
    req_atualizar_in     = 1'b1;
    atu_endereco_in      = v.e;
    atu_anterior_in      = v.a;
    atu_menor_vizinho_in = v.m;
    atu_distancia_in     = v.d;
  endtask

  function automatic atu_t rand_atu();
    atu_t v;
    v.e = AW'($urandom_range(0, 31));
    v.a = AW'($urandom_range(0, 31));
    v.m = CWD'($urandom_range(0, 15));
    v.d = DW'($urandom_range(0, 31));
    return v;
  endfunction

  // Advances until a pulse appears or the budget runs out; the caller judges the result.
  task automatic wait_pulse(input int max_cyc, output int cyc, output logic sd, output logic sa);
    cyc = 0;
    sd = 1'b0;
    sa = 1'b0;
    while (cyc < max_cyc && !sd && !sa) begin
      tick();
      cyc++;
      sd = er_desativar_out;
      sa = er_atualizar_out;
    end
  endtask

  // Emulates gerenciador_ativos accepting a request: busy for two cycles.
  task automatic ga_handshake();
    ga_ocupado_i = 1'b1;
    tick();
    tick();
    ga_ocupado_i = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    rst_n = 1'b0;
    ga_ocupado_i = 1'b0;
    ga_buffers_cheios_i = 1'b0;
    req_desativar_in = 1'b1;
    des_endereco_in = 5'd9;
    drive_atu('{e: 5'd1, a: 5'd2, m: 4'd3, d: 5'd4});
    tick();
    tick();
    checks++;
    if ({er_desativar_out, er_atualizar_out, er_endereco_out, er_anterior_out, er_menor_vizinho_out,
         er_distancia_out, er_fila_des_cheia_o, er_fila_atu_cheia_o, er_overflow_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got des=%b atu=%b end=%0d ant=%0d men=%0d dist=%0d ovf=%b, expected all 0",
               er_desativar_out, er_atualizar_out, er_endereco_out, er_anterior_out,
               er_menor_vizinho_out, er_distancia_out, er_overflow_o);
    end
    checks++;
    if (er_vazio_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_vazio: got %b expected 1", er_vazio_o);
    end
    rst_n = 1'b1;
    clear_inputs();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (er_desativar_out || er_atualizar_out) pulses++;
    end
    checks++;
    if (pulses !== 0 || er_vazio_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ignores_requests: got pulses=%0d vazio=%b expected 0 and 1", pulses, er_vazio_o);
    end
  endtask

  task automatic test_single_deactivate();
    req_desativar_in = 1'b1;
    des_endereco_in = 5'd5;
    tick();
    clear_inputs();
    checks++;
    if (er_desativar_out !== 1'b0 || er_vazio_o !== 1'b0) begin
      errors++;
      $display("FAIL single_queued: got pulse=%b vazio=%b expected 0 and 0", er_desativar_out, er_vazio_o);
    end
    tick();
    checks++;
    if (er_desativar_out !== 1'b1 || er_atualizar_out !== 1'b0 || er_endereco_out !== 5'd5) begin
      errors++;
      $display("FAIL single_pulse: got des=%b atu=%b end=%0d expected 1 0 5",
               er_desativar_out, er_atualizar_out, er_endereco_out);
    end
    tick();
    checks++;
    if (er_desativar_out !== 1'b0 || er_endereco_out !== 5'd5) begin
      errors++;
      $display("FAIL single_width: got des=%b end=%0d expected 0 5", er_desativar_out, er_endereco_out);
    end
    tick();
    tick();
    checks++;
    if (er_vazio_o !== 1'b1) begin
      errors++;
      $display("FAIL single_vazio_after: got %b expected 1", er_vazio_o);
    end
  endtask

  task automatic test_priority();
    int cyc, pulses;
    logic sd, sa;
    req_desativar_in = 1'b1;
    des_endereco_in = 5'd3;
    drive_atu('{e: 5'd7, a: 5'd2, m: 4'd4, d: 5'd9});
    tick();
    clear_inputs();
    wait_pulse(5, cyc, sd, sa);
    checks++;
    if (sd !== 1'b1 || sa !== 1'b0 || cyc !== 1 || er_endereco_out !== 5'd3) begin
      errors++;
      $display("FAIL priority_des_first: got des=%b atu=%b cyc=%0d end=%0d expected 1 0 1 3",
               sd, sa, cyc, er_endereco_out);
    end
    ga_ocupado_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (er_desativar_out || er_atualizar_out) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL priority_hold_busy: got %0d pulses expected 0", pulses);
    end
    ga_ocupado_i = 1'b0;
    wait_pulse(6, cyc, sd, sa);
    checks++;
    if (sa !== 1'b1 || sd !== 1'b0 || cyc !== 2 ||
        {er_endereco_out, er_anterior_out, er_menor_vizinho_out, er_distancia_out} !==
        {5'd7, 5'd2, 4'd4, 5'd9}) begin
      errors++;
      $display("FAIL priority_update_second: got atu=%b cyc=%0d fields=%0d/%0d/%0d/%0d expected 1 2 7/2/4/9",
               sa, cyc, er_endereco_out, er_anterior_out, er_menor_vizinho_out, er_distancia_out);
    end
    ga_handshake();
    tick();
    tick();
  endtask

  task automatic test_busy_hold();
    atu_t hb [3];
    int cyc, pulses;
    logic sd, sa;
    ga_ocupado_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      if (i < 3) begin
        hb[i] = rand_atu();
        drive_atu(hb[i]);
      end
      tick();
      if (er_desativar_out || er_atualizar_out) pulses++;
    end
    clear_inputs();
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL busy_hold_no_pulse: got %0d pulses expected 0", pulses);
    end
    ga_ocupado_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_pulse(8, cyc, sd, sa);
      checks++;
      if (sa !== 1'b1 || cyc !== ((k == 0) ? 1 : 2) ||
          {er_endereco_out, er_anterior_out, er_menor_vizinho_out, er_distancia_out} !== hb[k]) begin
        errors++;
        $display("FAIL busy_hold_order[%0d]: got atu=%b cyc=%0d fields=%h expected 1 %0d %h",
                 k, sa, cyc, {er_endereco_out, er_anterior_out, er_menor_vizinho_out, er_distancia_out},
                 (k == 0) ? 1 : 2, hb[k]);
      end
      ga_handshake();
    end
    last_atu = hb[2];
    tick();
  endtask

  task automatic test_slot_gating();
    atu_t sg;
    int cyc, pulses;
    logic sd, sa;
    sg = '{e: 5'd13, a: 5'd6, m: 4'd10, d: 5'd27};
    ga_buffers_cheios_i = 1'b1;
    drive_atu(sg);
    tick();
    clear_inputs();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (er_desativar_out || er_atualizar_out) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL slot_gated: got %0d pulses expected 0", pulses);
    end
    req_desativar_in = 1'b1;
    des_endereco_in = 5'd11;
    tick();
    clear_inputs();
    wait_pulse(4, cyc, sd, sa);
    checks++;
    if (sd !== 1'b1 || cyc !== 1 || er_endereco_out !== 5'd11) begin
      errors++;
      $display("FAIL slot_des_passes: got des=%b cyc=%0d end=%0d expected 1 1 11", sd, cyc, er_endereco_out);
    end
    checks++;
    if ({er_anterior_out, er_menor_vizinho_out, er_distancia_out} !== {last_atu.a, last_atu.m, last_atu.d}) begin
      errors++;
      $display("FAIL slot_payload_hold: got %0d/%0d/%0d expected %0d/%0d/%0d", er_anterior_out,
               er_menor_vizinho_out, er_distancia_out, last_atu.a, last_atu.m, last_atu.d);
    end
    ga_handshake();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (er_desativar_out || er_atualizar_out) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL slot_still_gated: got %0d pulses expected 0", pulses);
    end
    ga_buffers_cheios_i = 1'b0;
    wait_pulse(4, cyc, sd, sa);
    checks++;
    if (sa !== 1'b1 || cyc !== 1 ||
        {er_endereco_out, er_anterior_out, er_menor_vizinho_out, er_distancia_out} !== sg) begin
      errors++;
      $display("FAIL slot_update_released: got atu=%b cyc=%0d fields=%h expected 1 1 %h", sa, cyc,
               {er_endereco_out, er_anterior_out, er_menor_vizinho_out, er_distancia_out}, sg);
    end
    ga_handshake();
    tick();
  endtask

  task automatic test_overflow_wrap();
    atu_t ov [9];
    int cyc;
    logic sd, sa;
    for (int round = 0; round < 2; round++) begin
      ga_ocupado_i = 1'b1;
      for (int i = 0; i < ((round == 0) ? 9 : 8); i++) begin
        ov[i] = rand_atu();
        drive_atu(ov[i]);
        tick();
        if (round == 0 && i == 7) begin
          checks++;
          if (er_fila_atu_cheia_o !== 1'b1 || er_overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full_at_8: got cheia=%b ovf=%b expected 1 0", er_fila_atu_cheia_o, er_overflow_o);
          end
        end
      end
      clear_inputs();
      checks++;
      if (er_fila_atu_cheia_o !== 1'b1 || er_overflow_o !== 1'b1) begin
        errors++;
        $display("FAIL ovf_flags_round%0d: got cheia=%b ovf=%b expected 1 1", round, er_fila_atu_cheia_o,
                 er_overflow_o);
      end
      ga_ocupado_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
        wait_pulse(8, cyc, sd, sa);
        checks++;
        if (sa !== 1'b1 ||
            {er_endereco_out, er_anterior_out, er_menor_vizinho_out, er_distancia_out} !== ov[k]) begin
          errors++;
          $display("FAIL ovf_drain_round%0d[%0d]: got atu=%b fields=%h expected 1 %h", round, k, sa,
                   {er_endereco_out, er_anterior_out, er_menor_vizinho_out, er_distancia_out}, ov[k]);
        end
        ga_handshake();
      end
      tick();
      tick();
      checks++;
      if (er_vazio_o !== 1'b1 || er_fila_atu_cheia_o !== 1'b0 || er_overflow_o !== 1'b1) begin
        errors++;
        $display("FAIL ovf_after_drain_round%0d: got vazio=%b cheia=%b ovf=%b expected 1 0 1", round,
                 er_vazio_o, er_fila_atu_cheia_o, er_overflow_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, pulses;
    logic sd, sa;
    req_desativar_in = 1'b1;
    des_endereco_in = 5'd20;
    tick();
    clear_inputs();
    wait_pulse(4, cyc, sd, sa);
    ga_ocupado_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      req_desativar_in = 1'b1;
      des_endereco_in = AW'(i + 1);
      tick();
    end
    clear_inputs();
    checks++;
    if (sd !== 1'b1 || er_vazio_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_setup: got pulse=%b vazio=%b expected 1 0", sd, er_vazio_o);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({er_desativar_out, er_atualizar_out, er_endereco_out, er_anterior_out, er_menor_vizinho_out,
         er_distancia_out, er_fila_des_cheia_o, er_fila_atu_cheia_o, er_overflow_o} !== '0 ||
        er_vazio_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_outputs: got end=%0d ant=%0d ovf=%b vazio=%b expected 0 0 0 1",
               er_endereco_out, er_anterior_out, er_overflow_o, er_vazio_o);
    end
    rst_n = 1'b1;
    ga_ocupado_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (er_desativar_out || er_atualizar_out) pulses++;
    end
    checks++;
    if (pulses !== 0 || er_vazio_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_quiet: got pulses=%0d vazio=%b expected 0 1", pulses, er_vazio_o);
    end
  endtask

  // Transaction-level model: two FIFOs of outstanding requests plus the issuing rules.
  task automatic test_random();
    logic [AW-1:0] mq_des [$];
    atu_t mq_atu [$];
    atu_t lp, va;
    logic m_ovf, d_req, a_req, occ_d, chei_d, des_full, atu_full, des_empty_pre, sd, sa, gen;
    logic [AW-1:0] d_addr;
    int busy_left, last_pulse;
    rst_n = 1'b0;
    clear_inputs();
    ga_ocupado_i = 1'b0;
    ga_buffers_cheios_i = 1'b0;
    tick();
    rst_n = 1'b1;
    lp = '0;
    m_ovf = 1'b0;
    busy_left = 0;
    last_pulse = -10;
    for (int c = 0; c < 600; c++) begin
      gen = (c < 400);
      d_req = gen && ($urandom_range(0, 99) < 35);
      a_req = gen && ($urandom_range(0, 99) < 35);
      d_addr = AW'($urandom_range(0, 31));
      va = rand_atu();
      clear_inputs();
      req_desativar_in = d_req;
      des_endereco_in = d_addr;
      if (a_req) drive_atu(va);
      ga_ocupado_i = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (!gen) ga_buffers_cheios_i = 1'b0;
      else if ($urandom_range(0, 9) == 0) ga_buffers_cheios_i = ~ga_buffers_cheios_i;
      occ_d = ga_ocupado_i;
      chei_d = ga_buffers_cheios_i;
      des_full = (mq_des.size() == DEPTH);
      atu_full = (mq_atu.size() == DEPTH);
      des_empty_pre = (mq_des.size() == 0);
      tick();
      sd = er_desativar_out;
      sa = er_atualizar_out;
      checks++;
      if (sd && sa) begin
        errors++;
        $display("FAIL rand_both_pulses c=%0d: got des=1 atu=1 expected at most one", c);
      end
      if (sd || sa) begin
        checks++;
        if (occ_d !== 1'b0 || (c - last_pulse) < 3) begin
          errors++;
          $display("FAIL rand_issue_timing c=%0d: got busy=%b spacing=%0d expected 0 and >=3", c, occ_d,
                   c - last_pulse);
        end
        last_pulse = c;
        busy_left = $urandom_range(0, 4);
      end
      if (sd) begin
        checks++;
        if (mq_des.size() == 0) begin
          errors++;
          $display("FAIL rand_des_spurious c=%0d: got pulse expected none (queue empty)", c);
        end else begin
          lp.e = mq_des.pop_front();
        end
      end else if (sa) begin
        checks++;
        if (mq_atu.size() == 0 || !des_empty_pre || chei_d) begin
          errors++;
          $display("FAIL rand_atu_rule c=%0d: got update with qsize=%0d des_empty=%b cheios=%b expected >0 1 0",
                   c, mq_atu.size(), des_empty_pre, chei_d);
        end else begin
          lp = mq_atu.pop_front();
        end
      end
      checks++;
      if ({er_endereco_out, er_anterior_out, er_menor_vizinho_out, er_distancia_out} !== lp) begin
        errors++;
        $display("FAIL rand_payload c=%0d: got %h expected %h", c,
                 {er_endereco_out, er_anterior_out, er_menor_vizinho_out, er_distancia_out}, lp);
      end
      if (d_req) begin
        if (des_full) m_ovf = 1'b1;
        else mq_des.push_back(d_addr);
      end
      if (a_req) begin
        if (atu_full) m_ovf = 1'b1;
        else mq_atu.push_back(va);
      end
      checks++;
      if (er_overflow_o !== m_ovf || er_fila_des_cheia_o !== (mq_des.size() == DEPTH) ||
          er_fila_atu_cheia_o !== (mq_atu.size() == DEPTH)) begin
        errors++;
        $display("FAIL rand_flags c=%0d: got ovf=%b dcheia=%b acheia=%b expected %b %b %b", c, er_overflow_o,
                 er_fila_des_cheia_o, er_fila_atu_cheia_o, m_ovf, mq_des.size() == DEPTH,
                 mq_atu.size() == DEPTH);
      end
    end
    clear_inputs();
    ga_ocupado_i = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (mq_des.size() != 0 || mq_atu.size() != 0 || er_vazio_o !== 1'b1) begin
      errors++;
      $display("FAIL rand_drained: got model des=%0d atu=%0d vazio=%b expected 0 0 1", mq_des.size(),
               mq_atu.size(), er_vazio_o);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    ga_ocupado_i = 1'b0;
    ga_buffers_cheios_i = 1'b0;
    last_atu = '0;
    @(negedge clk);
    test_reset();
    test_single_deactivate();
    test_priority();
    test_busy_hold();
    test_slot_gating();
    test_overflow_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
